capture_replay_streamer: RTL and testbench

CAPTURE_REPLAY_STREAMER -- requirements
Module: capture_replay_streamer

---
 rtl/capture_replay_pkg.sv | 22 ++
 rtl/sample_ram.sv | 37 +++
 rtl/capture_replay_streamer.sv | 154 +++++++++++++++
 tb/tb_capture_replay_streamer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/capture_replay_pkg.sv
// capture_replay_pkg
//   Shared definitions for capture_replay_streamer. This includes the controller
//   state encoding, the default geometry constants, and a helper that sizes index
//   counters.
package capture_replay_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_GAP     = 2'd2,
    ST_STREAM  = 2'd3
  } state_e;

  localparam int unsigned DEF_SAMPLE_DATA_WIDTH = 8;
  localparam int unsigned DEF_CAPTURE_LENGTH    = 1000;

  // Counter width for a bound of n. The result is never narrower than 1 bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sample_ram.sv
// sample_ram
//   Simple dual-port sample store. It has one write port and one read port.
//   The read has one cycle of registered latency, so it can be inferred as block RAM.
//   Contents are not reset.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address (sampled every cycle)
//   rdata  out  registered read data for the address presented the previous cycle
module sample_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/capture_replay_streamer.sv
// capture_replay_streamer
//   On a start request this block captures CAPTURE_LENGTH samples. It then streams
//   NUM_FRAMES frames of CAPTURE_LENGTH samples each. Frames are separated by one
//   idle cycle. Frame k begins at buffer index k (mod CAPTURE_LENGTH) when
//   CAPTURE_REPLAY_ROTATE_EN is defined. Otherwise every frame begins at index 0.
//   Timing is the same in both builds.
// Ports:
//   clk           in   clock
//   rst           in   synchronous active-high reset
//   start         in   one-cycle capture request (ignored while busy and on the IDLE return cycle)
//   sample_valid  in   input sample strobe (used only while capturing)
//   sample_data   in   input sample
//   axiov         out  output sample valid
//   axiod         out  output sample (0 when axiov is low)
//   busy          out  high in any state other than IDLE
//   frame_done    out  high on the last sample of each frame
// Build option: CAPTURE_REPLAY_ROTATE_EN
module capture_replay_streamer
  import capture_replay_pkg::*;
#(
  parameter int unsigned SAMPLE_DATA_WIDTH = DEF_SAMPLE_DATA_WIDTH,
  parameter int unsigned CAPTURE_LENGTH    = DEF_CAPTURE_LENGTH,
  parameter int unsigned NUM_FRAMES        = 1001
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         sample_valid,
  input  logic [SAMPLE_DATA_WIDTH-1:0] sample_data,
  output logic                         axiov,
  output logic [SAMPLE_DATA_WIDTH-1:0] axiod,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int unsigned   IW         = idx_width(CAPTURE_LENGTH);
  localparam int unsigned   FW         = idx_width(NUM_FRAMES);
  localparam logic [IW-1:0] LAST_IDX   = IW'(CAPTURE_LENGTH - 1);
  localparam logic [FW-1:0] LAST_FRAME = FW'(NUM_FRAMES - 1);

`ifdef CAPTURE_REPLAY_ROTATE_EN
  localparam bit ROTATE = 1'b1;
`else
  localparam bit ROTATE = 1'b0;
`endif

  state_e          state_q, state_d;
  logic [IW-1:0]   wr_idx_q, wr_idx_d;
  logic [IW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [IW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [IW-1:0]   k_q, k_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic            ret_q, ret_d;
  logic            ram_we;
  logic [SAMPLE_DATA_WIDTH-1:0] ram_rdata;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
    return (x == LAST_IDX) ? '0 : x + IW'(1);
  endfunction

  // rd_ptr_q holds the address of the sample now on axiod. rd_ptr_d is the address
  // of the next sample, and it drives the RAM read port directly. In GAP this
  // address is the frame start, so the first sample is already registered when
  // STREAM begins.
  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    rd_cnt_d = rd_cnt_q;
    rd_ptr_d = rd_ptr_q;
    k_d      = k_q;
    frame_d  = frame_q;
    ret_d    = 1'b0;
    ram_we   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !ret_q) begin
          state_d  = ST_CAPTURE;
          wr_idx_d = '0;
        end
      end
      ST_CAPTURE: begin
        if (sample_valid) begin
          ram_we   = 1'b1;
          wr_idx_d = wrap_inc(wr_idx_q);
          if (wr_idx_q == LAST_IDX) begin
            state_d = ST_GAP;
            frame_d = '0;
            k_d     = '0;
          end
        end
      end
      ST_GAP: begin
        state_d  = ST_STREAM;
        rd_cnt_d = '0;
        rd_ptr_d = ROTATE ? k_q : '0;
      end
      ST_STREAM: begin
        rd_cnt_d = wrap_inc(rd_cnt_q);
        rd_ptr_d = wrap_inc(rd_ptr_q);
        if (rd_cnt_q == LAST_IDX) begin
          if (frame_q == LAST_FRAME) begin
            state_d = ST_IDLE;
            ret_d   = 1'b1;
          end else begin
            // GAP doubles as the one-cycle frame separator.
            state_d = ST_GAP;
            frame_d = frame_q + FW'(1);
            k_d     = wrap_inc(k_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_idx_q <= '0;
      rd_cnt_q <= '0;
      rd_ptr_q <= '0;
      k_q      <= '0;
      frame_q  <= '0;
      ret_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      rd_cnt_q <= rd_cnt_d;
      rd_ptr_q <= rd_ptr_d;
      k_q      <= k_d;
      frame_q  <= frame_d;
      ret_q    <= ret_d;
    end
  end

  sample_ram #(
    .DATA_WIDTH (SAMPLE_DATA_WIDTH),
    .DEPTH      (CAPTURE_LENGTH),
    .ADDR_WIDTH (IW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_idx_q),
    .wdata (sample_data),
    .raddr (rd_ptr_d),
    .rdata (ram_rdata)
  );

  assign axiov      = (state_q == ST_STREAM);
  assign axiod      = axiov ? ram_rdata : '0;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = axiov && (rd_cnt_q == LAST_IDX);

endmodule

// File: tb/tb_capture_replay_streamer.sv
// Directed bench for capture_replay_streamer with CAPTURE_LENGTH=8, NUM_FRAMES=3
// and 8-bit samples. Expected stream offsets come from a hand-written table.
module tb_capture_replay_streamer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       sample_valid;
  logic [7:0] sample_data;
  logic       axiov;
  logic [7:0] axiod;
  logic       busy;
  logic       frame_done;

  int unsigned n_cmp;
  int unsigned n_err;

`ifdef CAPTURE_REPLAY_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  // Offsets from the capture base for frames 0,1,2 with rotation.
  logic [7:0] rot_off [24] = '{
    8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7,
    8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd0,
    8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd0, 8'd1
  };
  logic [7:0] flat_off [8] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};

  capture_replay_streamer #(
    .SAMPLE_DATA_WIDTH (8),
    .CAPTURE_LENGTH    (8),
    .NUM_FRAMES        (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .axiov        (axiov),
    .axiod        (axiod),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one full capture and stream.
  //   toggle: insert a stall cycle before every valid sample.
  //   poke:   pulse start during CAPTURE and during STREAM.
  //   abort_f >= 0: assert rst at sample 3 of that frame.
  task automatic run(input logic [7:0] base, input bit toggle, input bit poke, input int abort_f);
    logic [7:0] exp_d;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("cap_busy", 32'(busy), 32'd1);
    for (int j = 0; j < 8; j++) begin
      if (toggle) begin
        sample_valid = 1'b0;
        sample_data  = 8'hEE;
        tick();
        chk("stall_axiov", 32'(axiov), 32'd0);
      end
      sample_valid = 1'b1;
      sample_data  = base + 8'(j);
      if (poke && j == 3) start = 1'b1;
      tick();
      start = 1'b0;
    end
    sample_valid = 1'b0;
    sample_data  = 8'h00;
    chk("gap_axiov", 32'(axiov), 32'd0);
    chk("gap_busy", 32'(busy), 32'd1);
    tick();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 8; i++) begin
        exp_d = base + (ROT ? rot_off[f*8+i] : flat_off[i]);
        chk("strm_axiov", 32'(axiov), 32'd1);
        chk("strm_axiod", 32'(axiod), 32'(exp_d));
        chk("strm_fdone", 32'(frame_done), (i == 7) ? 32'd1 : 32'd0);
        if (abort_f == f && i == 3) begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
          chk("abort_axiov", 32'(axiov), 32'd0);
          chk("abort_axiod", 32'(axiod), 32'd0);
          chk("abort_busy", 32'(busy), 32'd0);
          chk("abort_fdone", 32'(frame_done), 32'd0);
          tick();
          chk("abort_stay_idle", 32'(busy), 32'd0);
          return;
        end
        if (poke && i == 2) start = 1'b1;
        tick();
        start = 1'b0;
      end
      if (f < 2) begin
        chk("sep_axiov", 32'(axiov), 32'd0);
        chk("sep_axiod", 32'(axiod), 32'd0);
        chk("sep_fdone", 32'(frame_done), 32'd0);
        chk("sep_busy", 32'(busy), 32'd1);
        tick();
      end
    end
    chk("end_axiov", 32'(axiov), 32'd0);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_fdone", 32'(frame_done), 32'd0);
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    rst          = 1'b1;
    start        = 1'b0;
    sample_valid = 1'b0;
    sample_data  = 8'h00;
    tick();
    tick();
    chk("rst_axiov", 32'(axiov), 32'd0);
    chk("rst_axiod", 32'(axiod), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fdone", 32'(frame_done), 32'd0);
    rst = 1'b0;
    // sample_valid while idle must not start or write anything
    sample_valid = 1'b1;
    sample_data  = 8'h55;
    tick();
    sample_valid = 1'b0;
    chk("idle_valid_busy", 32'(busy), 32'd0);

    run(8'h10, 1'b0, 1'b0, -1);
    // start on the IDLE return cycle is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ret_start_busy", 32'(busy), 32'd0);

    run(8'h10, 1'b1, 1'b0, -1);
    run(8'h10, 1'b0, 1'b1, -1);
    run(8'h30, 1'b0, 1'b0, 1);
    run(8'h20, 1'b0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
